wb_ext_arbiter: RTL and testbench

Round-robin Wishbone arbiter that merges the NODES flattened external Wishbone master ports of the all-compute-tile system onto one shared external slave, such as a DDR controller or a shared SRAM. It sits directly downstream of the system's `wb_ext_*` bus. It holds each grant for a whole transaction or burst. A watchdog converts a hung slave into a bus error to the granted tile.

---
 rtl/optimsoc_pkg.sv | 10 +
 rtl/wb_ext_arbiter_arb_rr.sv | 38 +++
 rtl/wb_ext_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_ext_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/optimsoc_pkg.sv
// Shared Wishbone definitions used across the compute-tile system.
package optimsoc;

    // Wishbone cycle type identifiers (cti)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_ext_arbiter_arb_rr.sv
// Combinational round-robin pick: the first requester above the previous
// winner wins, wrapping around to the lowest index.
module arb_rr
    import optimsoc::*;
#(
    parameter int unsigned N = 1
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] gnt,
    output logic [N-1:0] nxt_gnt
);

    int unsigned last;
    logic        found;

    // Two passes: requesters above the last winner, then from index 0 upward
    always_comb begin
        last    = 0;
        nxt_gnt = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) last = i;
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (i > last)) begin
                nxt_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                nxt_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ext_arbiter.sv
// Round-robin arbiter merging NODES Wishbone masters onto one external slave.
// A grant is held until the owning master drops cyc; a watchdog turns a
// silent slave into a bus error for the granted master.
module wb_ext_arbiter
    import optimsoc::*;
#(
    parameter int unsigned NODES   = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [NODES*AW-1:0]       m_adr_i,
    input  logic [NODES*DW-1:0]       m_dat_i,
    input  logic [NODES*(DW/8)-1:0]   m_sel_i,
    input  logic [NODES*3-1:0]        m_cti_i,
    input  logic [NODES*2-1:0]        m_bte_i,
    input  logic [NODES-1:0]          m_cyc_i,
    input  logic [NODES-1:0]          m_stb_i,
    input  logic [NODES-1:0]          m_we_i,
    input  logic [NODES-1:0]          m_cab_i,
    output logic [NODES-1:0]          m_ack_o,
    output logic [NODES-1:0]          m_rty_o,
    output logic [NODES-1:0]          m_err_o,
    output logic [NODES*DW-1:0]       m_dat_o,

    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic                      s_cab_o,
    input  logic                      s_ack_i,
    input  logic                      s_rty_i,
    input  logic                      s_err_i,
    input  logic [DW-1:0]             s_dat_i
);

    localparam int unsigned SW    = DW / 8;
    localparam int unsigned GW    = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int unsigned WDW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WD_EN = (TIMEOUT != 0);
    localparam logic [WDW-1:0]   WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [NODES-1:0] ONE      = 1;
    localparam logic [NODES-1:0] LAST_RST = ONE << (NODES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [GW-1:0]    grant_idx;
    logic [NODES-1:0] last_gnt;
    logic [NODES-1:0] nxt_gnt;
    logic [GW-1:0]    nxt_idx;
    logic [WDW-1:0]   wd;
    logic             g_cyc;
    logic             g_stb;
    logic             s_resp;
    logic             wd_fire;

    arb_rr #(.N(NODES)) u_arb (
        .req     (m_cyc_i),
        .gnt     (last_gnt),
        .nxt_gnt (nxt_gnt)
    );

    // One-hot winner to binary index for the grant register
    always_comb begin
        nxt_idx = '0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (nxt_gnt[i]) nxt_idx = GW'(i);
        end
    end

    // Request path: the granted master drives the slave; idle drives zeros
    always_comb begin
        g_cyc   = 1'b0;
        g_stb   = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_we_o  = 1'b0;
        s_cab_o = 1'b0;
        for (int unsigned i = 0; i < NODES; i++) begin
            if (state == BUSY && grant_idx == GW'(i)) begin
                g_cyc   = m_cyc_i[i];
                g_stb   = m_stb_i[i];
                s_adr_o = m_adr_i[i*AW +: AW];
                s_dat_o = m_dat_i[i*DW +: DW];
                s_sel_o = m_sel_i[i*SW +: SW];
                s_cti_o = m_cti_i[i*3 +: 3];
                s_bte_o = m_bte_i[i*2 +: 2];
                s_we_o  = m_we_i[i];
                s_cab_o = m_cab_i[i];
            end
        end
        s_cyc_o = g_cyc;
        s_stb_o = g_cyc & g_stb;
    end

    // Response path: only the granted index sees responses; a real slave
    // response in the expiry cycle takes precedence over the forced error
    always_comb begin
        s_resp  = s_ack_i | s_err_i | s_rty_i;
        wd_fire = WD_EN && s_stb_o && !s_resp && (wd == WD_LAST);
        m_ack_o = '0;
        m_rty_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (state == BUSY) begin
            m_dat_o = {NODES{s_dat_i}};
            for (int unsigned i = 0; i < NODES; i++) begin
                if (grant_idx == GW'(i)) begin
                    m_ack_o[i] = s_ack_i;
                    m_rty_o[i] = s_rty_i;
                    m_err_o[i] = s_err_i | wd_fire;
                end
            end
        end
    end

    // Grant FSM and watchdog counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_gnt  <= LAST_RST;
            wd        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (|m_cyc_i) begin
                        state     <= BUSY;
                        grant_idx <= nxt_idx;
                        last_gnt  <= nxt_gnt;
                    end
                end
                BUSY: begin
                    if (!g_cyc) state <= IDLE;
                    if (WD_EN && s_stb_o && !s_resp && !wd_fire) begin
                        wd <= wd + WDW'(1);
                    end else begin
                        wd <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Self-checking bench for wb_ext_arbiter with four masters and TIMEOUT=8.
module tb_wb_ext_arbiter;
    import optimsoc::*;

    localparam int unsigned NODES = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NODES*AW-1:0]     m_adr_i;
    logic [NODES*DW-1:0]     m_dat_i;
    logic [NODES*4-1:0]      m_sel_i;
    logic [NODES*3-1:0]      m_cti_i;
    logic [NODES*2-1:0]      m_bte_i;
    logic [NODES-1:0]        m_cyc_i, m_stb_i, m_we_i, m_cab_i;
    logic [NODES-1:0]        m_ack_o, m_rty_o, m_err_o;
    logic [NODES*DW-1:0]     m_dat_o;
    logic [AW-1:0]           s_adr_o;
    logic [DW-1:0]           s_dat_o;
    logic [3:0]              s_sel_o;
    logic [2:0]              s_cti_o;
    logic [1:0]              s_bte_o;
    logic                    s_cyc_o, s_stb_o, s_we_o, s_cab_o;
    logic                    s_ack_i, s_rty_i, s_err_i;
    logic [DW-1:0]           s_dat_i;

    wb_ext_arbiter #(.NODES(NODES), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_cab_i(m_cab_i),
        .m_ack_o(m_ack_o), .m_rty_o(m_rty_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o),
        .s_ack_i(s_ack_i), .s_rty_i(s_rty_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned node;
        bit          err;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [2:0]  cti;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        int unsigned lat;
        bit          we;
        int unsigned exp_node;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc_cnt = 0;
    int unsigned slave_lat = 0;
    int unsigned slave_cnt = 0;
    bit          slave_mute = 1'b0;
    bit [3:0]    resp_seen = '0;
    int unsigned resp_cycle [4];
    int unsigned t0, t1;
    vec_t        vt [9];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] adr_of(input int unsigned n, input int unsigned i);
        return 32'h100 * (n + 1) + i * 4;
    endfunction

    function automatic logic [31:0] dat_of(input int unsigned n, input int unsigned i);
        return 32'hD000_0000 | (n << 8) | i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned n, input logic [31:0] adr, input logic [31:0] dat,
                         input bit we, input logic [2:0] cti, input bit cyc);
        m_adr_i[n*AW +: AW] = adr;
        m_dat_i[n*DW +: DW] = dat;
        m_sel_i[n*4 +: 4]   = 4'hF;
        m_cti_i[n*3 +: 3]   = cti;
        m_bte_i[n*2 +: 2]   = 2'b00;
        m_we_i[n]           = we;
        m_cab_i[n]          = 1'b0;
        m_cyc_i[n]          = cyc;
        m_stb_i[n]          = cyc;
    endtask

    task automatic push(input int unsigned node, input bit err, input bit we,
                        input logic [31:0] adr, input logic [31:0] wdat, input logic [2:0] cti);
        exp_t e;
        e.node = node; e.err = err; e.we = we; e.adr = adr; e.wdat = wdat; e.cti = cti;
        sbq.push_back(e);
    endtask

    task automatic wait_resp(input int unsigned node, input int unsigned budget);
        bit done = 1'b0;
        for (int unsigned c = 0; c < budget && !done; c++) begin
            tick();
            if (resp_seen[node]) begin
                resp_seen[node] = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout node %0d: no response in %0d cycles, expected one", node, budget);
        end
    endtask

    // Slave model (negedge) and response monitor / scoreboard (negedge + 2)
    initial begin
        s_ack_i = 1'b0; s_rty_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        forever begin
            @(negedge clk);
            if (s_stb_o && !slave_mute) begin
                if (slave_cnt >= slave_lat) begin
                    s_ack_i   = 1'b1;
                    s_dat_i   = rd_data(s_adr_o);
                    slave_cnt = 0;
                end else begin
                    s_ack_i   = 1'b0;
                    slave_cnt = slave_cnt + 1;
                end
            end else begin
                s_ack_i   = 1'b0;
                slave_cnt = 0;
            end
            #2;
            if ((m_ack_o | m_err_o) != '0) begin
                for (int unsigned i = 0; i < NODES; i++) begin
                    if (m_ack_o[i] || m_err_o[i]) begin
                        resp_seen[i]  = 1'b1;
                        resp_cycle[i] = cyc_cnt;
                    end
                end
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got ack=%b err=%b, expected none", m_ack_o, m_err_o);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("resp_ack_vec", m_ack_o, mon_e.err ? 4'b0000 : (4'b0001 << mon_e.node));
                    chk("resp_err_vec", m_err_o, mon_e.err ? (4'b0001 << mon_e.node) : 4'b0000);
                    chk("resp_adr", s_adr_o, mon_e.adr);
                    chk("resp_cti", s_cti_o, mon_e.cti);
                    chk("resp_we", s_we_o, mon_e.we);
                    if (mon_e.we) chk("resp_wdat", s_dat_o, mon_e.wdat);
                    else if (!mon_e.err) chk("resp_rdat", m_dat_o[mon_e.node*DW +: DW], rd_data(mon_e.adr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b1011, 1, 1'b0, 0};
        vt[1] = '{4'b1010, 0, 1'b1, 1};
        vt[2] = '{4'b1001, 2, 1'b0, 3};
        vt[3] = '{4'b0011, 0, 1'b0, 0};
        vt[4] = '{4'b0010, 1, 1'b1, 1};
        vt[5] = '{4'b0101, 0, 1'b0, 2};
        vt[6] = '{4'b1101, 2, 1'b1, 3};
        vt[7] = '{4'b0101, 0, 1'b0, 0};
        vt[8] = '{4'b0100, 1, 1'b0, 2};

        rst = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_cab_i = '0;
        tick(); tick(); tick();
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_s_stb", s_stb_o, 1'b0);
        chk("rst_s_adr", s_adr_o, 32'h0);
        chk("rst_m_ack", m_ack_o, 4'b0000);
        chk("rst_m_err", m_err_o, 4'b0000);
        rst = 1'b0;
        tick();

        // Round-robin order table: waiting masters keep cyc high
        for (int unsigned i = 0; i < 9; i++) begin
            slave_lat = vt[i].lat;
            for (int unsigned n = 0; n < NODES; n++) begin
                drive(n, adr_of(n, i), dat_of(n, i), vt[i].we, CTI_CLASSIC, vt[i].mask[n]);
            end
            push(vt[i].exp_node, 1'b0, vt[i].we, adr_of(vt[i].exp_node, i),
                 dat_of(vt[i].exp_node, i), CTI_CLASSIC);
            wait_resp(vt[i].exp_node, 40);
            m_cyc_i[vt[i].exp_node] = 1'b0;
            m_stb_i[vt[i].exp_node] = 1'b0;
            tick();
        end
        m_cyc_i = '0; m_stb_i = '0;
        tick(); tick();

        // Single master classic write, slave waits 3 cycles
        slave_lat = 3;
        t0 = cyc_cnt;
        drive(2, 32'h100, 32'hDEADBEEF, 1'b1, CTI_CLASSIC, 1'b1);
        #1 chk("single_cyc_same_cycle", s_cyc_o, 1'b0);
        push(2, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, CTI_CLASSIC);
        tick();
        chk("single_cyc_next_cycle", s_cyc_o, 1'b1);
        chk("single_adr", s_adr_o, 32'h100);
        chk("single_dat", s_dat_o, 32'hDEADBEEF);
        chk("single_sel", s_sel_o, 4'hF);
        wait_resp(2, 40);
        chk("single_ack_cycle", resp_cycle[2], t0 + 4);
        drive(2, 32'h100, 32'hDEADBEEF, 1'b1, CTI_CLASSIC, 1'b0);
        #1 chk("single_release_cyc", s_cyc_o, 1'b0);
        tick(); tick();

        // INCR burst on node 1; node 0 requests mid-burst
        slave_lat = 0;
        drive(1, 32'h2000, 32'h0, 1'b0, CTI_INCR, 1'b1);
        push(1, 1'b0, 1'b0, 32'h2000, 32'h0, CTI_INCR);
        for (int unsigned b = 0; b < 4; b++) begin
            wait_resp(1, 40);
            if (b == 0) drive(0, 32'h3000, 32'h0, 1'b0, CTI_CLASSIC, 1'b1);
            if (b < 3) begin
                drive(1, 32'h2000 + (b + 1) * 4, 32'h0, 1'b0, (b == 2) ? CTI_EOB : CTI_INCR, 1'b1);
                push(1, 1'b0, 1'b0, 32'h2000 + (b + 1) * 4, 32'h0, (b == 2) ? CTI_EOB : CTI_INCR);
            end
        end
        drive(1, 32'h0, 32'h0, 1'b0, CTI_CLASSIC, 1'b0);
        #1 chk("burst_release_cyc", s_cyc_o, 1'b0);
        tick();
        chk("burst_idle_cyc", s_cyc_o, 1'b0);
        push(0, 1'b0, 1'b0, 32'h3000, 32'h0, CTI_CLASSIC);
        tick();
        chk("burst_next_grant_cyc", s_cyc_o, 1'b1);
        chk("burst_next_grant_adr", s_adr_o, 32'h3000);
        wait_resp(0, 40);
        drive(0, 32'h0, 32'h0, 1'b0, CTI_CLASSIC, 1'b0);
        tick(); tick();

        // Watchdog: silent slave gives an error in the 8th strobe cycle
        slave_mute = 1'b1;
        t0 = cyc_cnt;
        drive(0, 32'h4000, 32'h0, 1'b0, CTI_CLASSIC, 1'b1);
        push(0, 1'b1, 1'b0, 32'h4000, 32'h0, CTI_CLASSIC);
        wait_resp(0, 40);
        chk("wd_err_cycle", resp_cycle[0], t0 + 8);
        drive(0, 32'h0, 32'h0, 1'b0, CTI_CLASSIC, 1'b0);
        tick();
        // Retry where the ack lands exactly in the expiry cycle
        slave_mute = 1'b0;
        slave_lat  = 7;
        t1 = cyc_cnt;
        drive(0, 32'h4004, 32'h0, 1'b0, CTI_CLASSIC, 1'b1);
        push(0, 1'b0, 1'b0, 32'h4004, 32'h0, CTI_CLASSIC);
        wait_resp(0, 40);
        chk("wd_ack_wins_cycle", resp_cycle[0], t1 + 8);
        drive(0, 32'h0, 32'h0, 1'b0, CTI_CLASSIC, 1'b0);
        tick(); tick();

        // Reset during the second beat of a burst
        slave_lat = 0;
        drive(1, 32'h5000, 32'h0, 1'b0, CTI_INCR, 1'b1);
        push(1, 1'b0, 1'b0, 32'h5000, 32'h0, CTI_INCR);
        wait_resp(1, 40);
        drive(1, 32'h5004, 32'h0, 1'b0, CTI_INCR, 1'b1);
        push(1, 1'b0, 1'b0, 32'h5004, 32'h0, CTI_INCR);
        drive(0, 32'h6000, 32'h0, 1'b0, CTI_CLASSIC, 1'b1);
        drive(2, 32'h7000, 32'h0, 1'b0, CTI_CLASSIC, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstmid_beat2_acked", resp_seen[1], 1'b1);
        resp_seen = '0;
        chk("rstmid_s_cyc", s_cyc_o, 1'b0);
        chk("rstmid_s_stb", s_stb_o, 1'b0);
        chk("rstmid_s_adr", s_adr_o, 32'h0);
        chk("rstmid_s_cti", s_cti_o, 3'b000);
        chk("rstmid_m_ack", m_ack_o, 4'b0000);
        chk("rstmid_m_dat_any", |m_dat_o, 1'b0);
        rst = 1'b0;
        push(0, 1'b0, 1'b0, 32'h6000, 32'h0, CTI_CLASSIC);
        tick();
        chk("rstmid_first_grant_cyc", s_cyc_o, 1'b1);
        chk("rstmid_first_grant_adr", s_adr_o, 32'h6000);
        wait_resp(0, 40);
        m_cyc_i = '0; m_stb_i = '0;
        tick(); tick(); tick();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
